// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug run controller: state encoding,
// command bytes and snapshot stream geometry.
package dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DUMP   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam logic [7:0] CMD_RUN_DEF   = 8'h63;
  localparam logic [7:0] CMD_STEP_DEF  = 8'h73;
  localparam logic [7:0] CMD_BREAK_DEF = 8'h62;
  localparam logic [7:0] CMD_DUMP_DEF  = 8'h64;

  localparam int NUM_REGS_DEF   = 32;
  localparam int DUMP_HDR_BYTES = 8;
  localparam int DUMP_LEN       = DUMP_HDR_BYTES + 4 * NUM_REGS_DEF;
  // Sized for the largest register file, so it covers every legal NUM_REGS.
  localparam int BYTE_IDX_W     = $clog2(DUMP_LEN + 1);

  function automatic int dump_len(input int num_regs);
    return DUMP_HDR_BYTES + 4 * num_regs;
  endfunction

  // sel 0 selects the most significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
    case (sel)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/dbg_dump_serializer.sv
// Streams the PC / cycle-count / register-file snapshot as bytes over a
// valid/ready handshake, MSB-first per 32-bit word.
module dbg_dump_serializer
  import dbg_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] pc,
  input  logic [31:0] cnt,
  input  logic [31:0] reg_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic [4:0]  reg_addr,
  output logic        done
);

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(dump_len(NUM_REGS) - 1);
  localparam logic [BYTE_IDX_W-1:0] HDR_IDX  = BYTE_IDX_W'(DUMP_HDR_BYTES);

  logic [BYTE_IDX_W-1:0] byte_idx;
  logic [BYTE_IDX_W-1:0] idx_inc;
  logic                  load_pend;
  logic                  xfer;
  logic                  word_edge;

  function automatic logic [4:0] addr_of(input logic [BYTE_IDX_W-1:0] idx);
    logic [BYTE_IDX_W-1:0] off;
    off = idx - HDR_IDX;
    if (idx < HDR_IDX) return 5'd0;
    return 5'(off >> 2);
  endfunction

  function automatic logic [7:0] byte_of(input logic [BYTE_IDX_W-1:0] idx,
                                         input logic [31:0] pc_w,
                                         input logic [31:0] cnt_w,
                                         input logic [31:0] reg_w);
    if (idx < BYTE_IDX_W'(4)) return word_byte(pc_w, idx[1:0]);
    if (idx < HDR_IDX)        return word_byte(cnt_w, idx[1:0]);
    return word_byte(reg_w, idx[1:0]);
  endfunction

  assign xfer    = tx_valid & tx_ready;
  assign done    = xfer && (byte_idx == LAST_IDX);
  assign idx_inc = byte_idx + BYTE_IDX_W'(1);
  // Crossing into a new register word needs reg_addr to settle before the
  // combinational read data is valid, so one bubble cycle is inserted there.
  // The first register word needs none: reg_addr is already 0 for the header.
  assign word_edge = (idx_inc >= BYTE_IDX_W'(DUMP_HDR_BYTES + 4)) && (idx_inc[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      byte_idx  <= '0;
      reg_addr  <= 5'd0;
      load_pend <= 1'b0;
    end else if (start) begin
      tx_valid  <= 1'b0;
      byte_idx  <= '0;
      reg_addr  <= 5'd0;
      load_pend <= 1'b1;
    end else if (load_pend) begin
      tx_valid  <= 1'b1;
      tx_data   <= byte_of(byte_idx, pc, cnt, reg_data);
      load_pend <= 1'b0;
    end else if (xfer) begin
      if (done) begin
        tx_valid <= 1'b0;
        byte_idx <= '0;
        reg_addr <= 5'd0;
      end else begin
        byte_idx <= idx_inc;
        reg_addr <= addr_of(idx_inc);
        if (word_edge) begin
          tx_valid  <= 1'b0;
          load_pend <= 1'b1;
        end else begin
          tx_data <= byte_of(idx_inc, pc, cnt, reg_data);
        end
      end
    end
  end

endmodule

// File: rtl/debug_run_ctrl.sv
// Debug sequencer for the 5-stage pipeline: owns the stop_debug freeze line,
// decodes UART command bytes and triggers snapshot dumps.
module debug_run_ctrl
  import dbg_pkg::*;
#(
  parameter int         NUM_REGS  = NUM_REGS_DEF,
  parameter logic [7:0] CMD_RUN   = CMD_RUN_DEF,
  parameter logic [7:0] CMD_STEP  = CMD_STEP_DEF,
  parameter logic [7:0] CMD_BREAK = CMD_BREAK_DEF,
  parameter logic [7:0] CMD_DUMP  = CMD_DUMP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_data,
  output logic        cmd_ready,
  input  logic        halt_in,
  input  logic [31:0] pc_in,
  output logic [4:0]  reg_addr,
  input  logic [31:0] reg_data,
  output logic        stop_debug,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        busy
);

  state_t      state;
  state_t      next_state;
  logic        halted;
  logic        set_halt;
  logic        dump_start;
  logic        dump_done;
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      stop_debug <= 1'b1;
      busy       <= 1'b0;
      halted     <= 1'b0;
      cycle_cnt  <= 32'd0;
    end else begin
      state      <= next_state;
      // The pipeline advances exactly in the cycles spent in RUN or STEP.
      stop_debug <= !((next_state == ST_RUN) || (next_state == ST_STEP));
      busy       <= !((next_state == ST_IDLE) || (next_state == ST_HALTED));
      if (set_halt) halted <= 1'b1;
      if (!stop_debug) cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    set_halt   = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_data == CMD_RUN)       next_state = ST_RUN;
          else if (cmd_data == CMD_STEP) next_state = ST_STEP;
          else if (cmd_data == CMD_DUMP) next_state = ST_DUMP;
        end
      end
      ST_RUN: begin
        cmd_ready = 1'b1;
        // A HALT reaching WB wins over a simultaneous break request.
        if (halt_in) begin
          set_halt   = 1'b1;
          next_state = ST_DUMP;
        end else if (cmd_valid && (cmd_data == CMD_BREAK)) begin
          next_state = ST_DUMP;
        end
      end
      ST_STEP: begin
        if (halt_in) set_halt = 1'b1;
        next_state = ST_DUMP;
      end
      ST_DUMP: begin
        if (dump_done) next_state = halted ? ST_HALTED : ST_IDLE;
      end
      ST_HALTED: begin
        cmd_ready = 1'b1;
        if (cmd_valid && (cmd_data == CMD_DUMP)) next_state = ST_DUMP;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign dump_start = (next_state == ST_DUMP) && (state != ST_DUMP);

  dbg_dump_serializer #(
    .NUM_REGS (NUM_REGS)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .start    (dump_start),
    .pc       (pc_in),
    .cnt      (cycle_cnt),
    .reg_data (reg_data),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .reg_addr (reg_addr),
    .done     (dump_done)
  );

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Randomized bench for debug_run_ctrl against a command-level reference model.
module tb_debug_run_ctrl;

  localparam int         NREG    = 32;
  localparam int         DLEN    = 8 + 4 * NREG;
  localparam logic [7:0] C_RUN   = 8'h63;
  localparam logic [7:0] C_STEP  = 8'h73;
  localparam logic [7:0] C_BREAK = 8'h62;
  localparam logic [7:0] C_DUMP  = 8'h64;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [7:0]  cmd_data;
  logic        cmd_ready;
  logic        halt_in;
  logic [31:0] pc_in;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic        stop_debug;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        busy;

  logic [31:0] regs [NREG];
  assign reg_data = regs[reg_addr];

  always #5 clk = ~clk;

  debug_run_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .halt_in    (halt_in),
    .pc_in      (pc_in),
    .reg_addr   (reg_addr),
    .reg_data   (reg_data),
    .stop_debug (stop_debug),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: pipeline cycles executed so far and the sticky halt flag.
  logic [31:0] m_cnt;
  bit          m_halted;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input int i);
    logic [31:0] w;
    if (i < 4)      w = pc_in;
    else if (i < 8) w = m_cnt;
    else            w = regs[(i - 8) / 4];
    return w[8 * (3 - (i % 4)) +: 8];
  endfunction

  function automatic logic [7:0] junk_byte(input bit allow_break);
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255));
    while (b == C_RUN || b == C_STEP || b == C_DUMP || (!allow_break && b == C_BREAK));
    return b;
  endfunction

  task automatic send_cmd(input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_data  = b;
    chk("cmd_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_cnt    = 32'd0;
    m_halted = 1'b0;
  endtask

  // Called in the first DUMP cycle; mode 0: always ready, 1: ready 1-of-3, 2: random.
  task automatic collect_dump(input int mode, input int stop_at);
    int n = 0;
    int cyc = 0;
    int hold_err = 0;
    int frz_err = 0;
    bit prev_stall = 1'b0;
    bit rdy;
    logic [7:0] prev_data = 8'h00;
    chk("tx_valid_entry", tx_valid, 1'b0);
    chk("busy_dump", busy, 1'b1);
    while (n < stop_at && cyc < 4000) begin
      if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) hold_err++;
      if (stop_debug !== 1'b1) frz_err++;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 2);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      tx_ready = rdy;
      if (tx_valid && rdy) begin
        chk($sformatf("byte%0d", n), tx_data, exp_byte(n));
        n++;
      end
      prev_stall = tx_valid && !rdy;
      prev_data  = tx_data;
      tick();
      cyc++;
    end
    tx_ready = 1'b0;
    chk("dump_count", n, stop_at);
    chk("dump_hold", hold_err, 0);
    chk("dump_frozen", frz_err, 0);
    if (stop_at == DLEN) begin
      chk("tx_valid_end", tx_valid, 1'b0);
      chk("busy_end", busy, 1'b0);
      chk("stop_end", stop_debug, 1'b1);
    end
  endtask

  task automatic do_step(input bit hlt, input int mode);
    send_cmd(C_STEP);
    chk("step_stop_lo", stop_debug, 1'b0);
    halt_in = hlt;
    tick();
    halt_in = 1'b0;
    chk("step_stop_hi", stop_debug, 1'b1);
    m_cnt = m_cnt + 32'd1;
    if (hlt) m_halted = 1'b1;
    collect_dump(mode, DLEN);
  endtask

  // how: 0 = halt_in ends the run, 1 = CMD_BREAK, 2 = both in the same cycle.
  task automatic do_run(input int n, input int how, input int mode);
    send_cmd(C_RUN);
    chk("run_stop", stop_debug, 1'b0);
    chk("run_busy", busy, 1'b1);
    for (int k = 1; k < n; k++) begin
      if (k == 2) begin
        cmd_valid = 1'b1;
        cmd_data  = junk_byte(1'b0);
        chk("run_cmd_ready", cmd_ready, 1'b1);
      end
      tick();
      cmd_valid = 1'b0;
    end
    if (how != 1) halt_in = 1'b1;
    if (how != 0) begin
      cmd_valid = 1'b1;
      cmd_data  = C_BREAK;
    end
    tick();
    halt_in   = 1'b0;
    cmd_valid = 1'b0;
    m_cnt = m_cnt + 32'(n);
    if (how != 1) m_halted = 1'b1;
    collect_dump(mode, DLEN);
  endtask

  task automatic probe_ignored(input logic [7:0] b);
    send_cmd(b);
    tick();
    tick();
    chk("ignored_stop", stop_debug, 1'b1);
    chk("ignored_busy", busy, 1'b0);
    chk("ignored_txv", tx_valid, 1'b0);
  endtask

  task automatic randomize_snapshot();
    pc_in = $urandom;
    for (int i = 0; i < NREG; i++) regs[i] = $urandom;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    halt_in   = 1'b0;
    tx_ready  = 1'b0;
    pc_in     = 32'h0000_0004;
    for (int i = 0; i < NREG; i++) regs[i] = 32'(i);
    do_reset();

    repeat (10) tick();
    chk("rst_stop", stop_debug, 1'b1);
    chk("rst_txv", tx_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_addr", reg_addr, 5'd0);

    // Single step with ascending register contents.
    do_step(1'b0, 0);
    probe_ignored(junk_byte(1'b1));

    // Break after 20 cycles, then resume from 21.
    do_reset();
    do_run(20, 1, 2);
    do_run(5, 1, 0);
    probe_ignored(C_BREAK);

    // HALT after 50 cycles; RUN/STEP are then ignored, DUMP still works.
    do_reset();
    do_run(50, 0, 0);
    probe_ignored(C_RUN);
    probe_ignored(C_STEP);
    send_cmd(C_DUMP);
    collect_dump(1, DLEN);
    probe_ignored(C_RUN);

    // Reset in the middle of a dump, then a clean restart.
    do_reset();
    do_run(7, 1, 0);
    send_cmd(C_DUMP);
    collect_dump(0, 40);
    rst = 1'b1;
    tick();
    chk("midrst_txv", tx_valid, 1'b0);
    chk("midrst_stop", stop_debug, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    m_cnt    = 32'd0;
    m_halted = 1'b0;
    tick();
    send_cmd(C_DUMP);
    collect_dump(2, DLEN);

    // Randomized command mix.
    for (int it = 0; it < 24; it++) begin
      int op;
      randomize_snapshot();
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          if (m_halted) probe_ignored(C_STEP);
          else do_step(($urandom_range(0, 3) == 0), $urandom_range(0, 2));
        end
        1: begin
          if (m_halted) probe_ignored(C_RUN);
          else do_run($urandom_range(1, 60), $urandom_range(0, 2), $urandom_range(0, 2));
        end
        2: begin
          send_cmd(C_DUMP);
          collect_dump($urandom_range(0, 2), DLEN);
        end
        3: probe_ignored(junk_byte(1'b1));
        default: begin
          do_reset();
          chk("rnd_rst_stop", stop_debug, 1'b1);
          chk("rnd_rst_busy", busy, 1'b0);
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/debug_run_ctrl.md
Name: debug_run_ctrl

Overview:
- Debug sequencer for the 5-stage pipeline. It owns the stop_debug freeze line fed to every stage register (IF/ID/EXE/MEM/WB).
- Accepts byte commands from the debug UART receiver: free-run, single-step, break and dump.
- On halt or after each step, streams a snapshot (PC, cycle count, register file) to the UART transmitter through a valid/ready byte handshake.

Parameters:
NUM_REGS, 32, number of register-file entries dumped (1..32)
CMD_RUN, 8'h63, command byte: continuous run
CMD_STEP, 8'h73, command byte: single step
CMD_BREAK, 8'h62, command byte: stop a running program
CMD_DUMP, 8'h64, command byte: dump without advancing

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command byte available from UART RX
cmd_data  in  8  command byte
cmd_ready  out  1  command byte consumed this cycle when cmd_valid&cmd_ready
halt_in  in  1  HALT instruction reached WB (level, sampled each cycle)
pc_in  in  32  current fetch PC
reg_addr  out  5  register-file debug read address
reg_data  in  32  register-file debug read data (combinational from reg_addr)
stop_debug  out  1  1 = pipeline frozen; registered output
tx_valid  out  1  tx_data valid
tx_data  out  8  byte to transmit
tx_ready  in  1  UART TX accepts byte when tx_valid&tx_ready
busy  out  1  high in any state except IDLE and HALTED

Behaviour:
- Reset (sync, rst=1 at rising edge) values: state=IDLE, stop_debug=1, cycle_cnt=0, byte_idx=0, tx_valid=0, tx_data=0, reg_addr=0, halted flag=0. Reset mid-dump aborts the stream immediately; tx_valid drops the next edge.
- States: IDLE, RUN, STEP, DUMP, HALTED.
- IDLE:
  - stop_debug=1, cmd_ready=1.
  - CMD_RUN→RUN; CMD_STEP→STEP; CMD_DUMP→DUMP.
  - Any other byte is consumed and ignored.
- RUN:
  - stop_debug=0 from the cycle after entry. cycle_cnt+1 every cycle stop_debug=0, wrapping at 2^32.
  - cmd_ready=1; only CMD_BREAK acts (→DUMP), other bytes are dropped.
  - halt_in=1 → set halted, →DUMP.
  - halt_in and CMD_BREAK in the same cycle: treat as halt.
- STEP:
  - cmd_ready=0. stop_debug=0 for exactly one clock, cycle_cnt+1, then →DUMP with stop_debug=1.
  - halt_in sampled during the step cycle sets halted.
- DUMP:
  - stop_debug=1, cmd_ready=0.
  - Emit 8+4*NUM_REGS bytes in order: pc_in[31:24..7:0], cycle_cnt[31:24..7:0], then R0..R(NUM_REGS-1), each MSB-first.
  - reg_addr=(byte_idx-8)>>2 while byte_idx≥8, else 0.
  - tx_valid is asserted the cycle after entry. tx_data is registered and held stable until the transfer.
  - byte_idx advances only on tx_valid&tx_ready.
  - After the last transfer: tx_valid=0, byte_idx=0, →HALTED if halted else →IDLE.
  - tx_ready held low indefinitely → controller waits, no timeout.
- HALTED:
  - stop_debug=1, cmd_ready=1.
  - Only CMD_DUMP acts (→DUMP). CMD_RUN and CMD_STEP are consumed and ignored.
  - Exit only via rst.
- The pipeline is frozen (stop_debug=1) during any dump, so PC and register contents are stable across the whole stream.
- cmd_ready is combinational from state. All other outputs are registered.

Decomposition:
- Shared package dbg_pkg: state encoding (3-bit enum), command byte constants, DUMP_HDR_BYTES=8, localparam DUMP_LEN=8+4*NUM_REGS, byte-index width $clog2(DUMP_LEN+1).
- One natural sub-module: dbg_dump_serializer. It takes start, the snapshot words and the TX handshake, and returns done plus reg_addr. The FSM stays in debug_run_ctrl.

Test Plan:
- Reset, then idle 10 cycles → stop_debug=1, tx_valid=0, busy=0, cmd_ready=1.
- CMD_STEP with tx_ready=1, pc_in=32'h0000_0004, all regs=i → exactly one cycle stop_debug=0, then 136 bytes: 00 00 00 04, 00 00 00 01, 00 00 00 00, 00 00 00 01 … last 4 = 00 00 00 1F → IDLE.
- CMD_RUN, halt_in asserted after 50 running cycles → cycle_cnt bytes = 00 00 00 32, state HALTED. A following CMD_RUN is consumed and ignored, stop_debug stays 1.
- CMD_RUN, CMD_BREAK at cycle 20 with halt_in=0 → dump, then IDLE (not HALTED). A second CMD_RUN resumes counting from 21.
- DUMP with tx_ready toggling 1-of-3 cycles → tx_data stable while tx_valid&!tx_ready, no byte lost or duplicated, total 136 transfers.
- rst asserted at byte 40 of a dump → next edge tx_valid=0, stop_debug=1, cycle_cnt=0. A new CMD_DUMP restarts at byte 0.
